// File: rtl/control_pipe.sv
// control_pipe: decode-stage control unit with load-use hazard stalls, flush and bubble counting
module control_pipe #(
    parameter int MCODEBITS    = 4,
    parameter int RADDR        = 3,
    parameter int STALL_CYCLES = 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [MCODEBITS-1:0] instr,
    input  logic                 in_valid,
    input  logic [RADDR-1:0]     rs,
    input  logic [RADDR-1:0]     rt,
    input  logic [RADDR-1:0]     rd,
    input  logic                 flush,
    output logic                 stall_out,
    output logic                 out_valid,
    output logic                 RegDst,
    output logic                 Branch,
    output logic                 MemRead,
    output logic                 MemtoReg,
    output logic                 MemWrite,
    output logic                 ALUSrc,
    output logic                 RegWrite,
    output logic [RADDR-1:0]     ex_rd,
    output logic                 illegal,
    output logic [7:0]           bubble_cnt
);
    typedef enum logic {RUN, STALL} state_t;
    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [6:0]       flags_q, flags_d, dec;
    logic             valid_q, valid_d, ill_q, ill_d;
    logic [RADDR-1:0] rd_q, rd_d;
    logic [7:0]       bcnt_q, bcnt_d;
    logic             bad, hazard, go;

    // flag order: {RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite}
    always_comb begin
        dec = '0;
        case (instr[3:1])
            3'b000, 3'b001, 3'b101: dec = 7'b1000001;
            3'b010, 3'b111:         dec = 7'b0000001;
            3'b011:                 dec = 7'b1011001;
            3'b100:                 dec = 7'b0000100;
            default:                dec = instr[0] ? 7'b0000011 : 7'b0100000;
        endcase
    end

    assign bad       = (instr >> 4) != '0;
    assign hazard    = state_q == RUN && in_valid && valid_q && flags_q[4] && (rd_q == rs || rd_q == rt);
    assign stall_out = Reset && !flush && (state_q == RUN ? hazard : cnt_q != 3'd0);
    assign go        = in_valid && !flush && !stall_out;

    // state and registered control bundle
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
            ill_q   <= 1'b0;
            rd_q    <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flags_q <= flags_d;
            valid_q <= valid_d;
            ill_q   <= ill_d;
            rd_q    <= rd_d;
            bcnt_q  <= bcnt_d;
        end
    end

    // stall sequencing: flush aborts, hazard enters STALL, counter drains to zero then resumes
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = RUN;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            state_d = hazard ? STALL : RUN;
            cnt_d   = hazard ? 3'(STALL_CYCLES - 1) : cnt_q;
        end else begin
            state_d = cnt_q != 3'd0 ? STALL : RUN;
            cnt_d   = cnt_q != 3'd0 ? cnt_q - 3'd1 : cnt_q;
        end
    end

    // next control bundle: anything other than a legal accepted instruction is a bubble
    always_comb begin
        valid_d = go && !bad;
        ill_d   = go && bad;
        flags_d = valid_d ? dec : '0;
        rd_d    = valid_d ? rd : rd_q;
        bcnt_d  = bcnt_q + 8'(stall_out && bcnt_q != 8'hff);
    end

    assign {RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite} = flags_q;
    assign out_valid  = valid_q;
    assign ex_rd      = rd_q;
    assign illegal    = ill_q;
    assign bubble_cnt = bcnt_q;
endmodule

// File: doc/control_pipe.md
CONTROL_PIPE -- requirements
Module: control_pipe

Interface
REQ-001 SHALL have parameter MCODEBITS, default 4, opcode field width (>=4).
REQ-002 SHALL have parameter RADDR, default 3, register address width.
REQ-003 SHALL have parameter STALL_CYCLES, default 1, bubbles inserted per load-use hazard (1..7).
REQ-004 SHALL have port Clk  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port Reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port instr  in  MCODEBITS  opcode of the instruction in decode.
REQ-007 SHALL have port in_valid  in  1  instr/rs/rt/rd valid this cycle.
REQ-008 SHALL have ports rs, rt, rd  in  RADDR each  source and destination register addresses of the decode instruction.
REQ-009 SHALL have port flush  in  1  branch taken; discard the decode instruction.
REQ-010 SHALL have port stall_out  out  1  hold fetch/decode this cycle (combinational).
REQ-011 SHALL have port out_valid  out  1  registered control bundle is a real instruction.
REQ-012 SHALL have ports RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite  out  1 each  registered control bundle.
REQ-013 SHALL have port ex_rd  out  RADDR  registered rd of the issued instruction.
REQ-014 SHALL have port illegal  out  1  registered one-cycle pulse for an undecodable opcode.
REQ-015 SHALL have port bubble_cnt  out  8  saturating count of hazard bubbles.

Function
REQ-016 Decode op = instr[3:0]; instr[MCODEBITS-1:4] nonzero SHALL mark the instruction illegal.
REQ-017 Decode table (unlisted flags 0): 000x add RegDst,RegWrite; 001x mov RegDst,RegWrite; 010x xor RegWrite; 011x load MemtoReg,MemRead,RegDst,RegWrite; 100x store MemWrite; 101x shift RegDst,RegWrite; 1100 bne Branch; 1101 set ALUSrc,RegWrite; 111x and RegWrite.
REQ-018 Latency SHALL be one cycle: instruction accepted at edge N drives outputs from edge N onward until edge N+1.
REQ-019 A bubble SHALL set out_valid and all seven control flags to 0; ex_rd holds its previous value.
REQ-020 in_valid=0 with no other event SHALL issue a bubble.
REQ-021 FSM states RUN and STALL plus a 3-bit down-counter cnt.
REQ-022 hazard = state RUN & in_valid & out_valid & MemRead & (ex_rd==rs | ex_rd==rt).
REQ-023 In RUN with hazard: stall_out=1; at edge issue bubble, state<=STALL, cnt<=STALL_CYCLES-1, bubble_cnt++.
REQ-024 In STALL with cnt!=0: stall_out=1; at edge issue bubble, cnt--, bubble_cnt++.
REQ-025 In STALL with cnt==0: stall_out=0; at edge decode the held instruction normally, state<=RUN; no hazard check.
REQ-026 Total bubbles per hazard SHALL equal STALL_CYCLES exactly.
REQ-027 flush=1 in any state SHALL take priority: stall_out=0; at edge issue bubble, state<=RUN, cnt<=0, bubble_cnt unchanged, no illegal pulse.
REQ-028 Illegal instruction (in_valid=1, no flush, no stall) SHALL issue a bubble and set illegal=1 for one cycle; illegal is 0 otherwise.
REQ-029 bubble_cnt SHALL saturate at 255 and never wrap.
REQ-030 Flush and hazard in the same cycle SHALL resolve as flush only.

Reset
REQ-031 Reset=0 SHALL immediately, independent of Clk, force state RUN, cnt 0, out_valid, all control flags, illegal 0, ex_rd 0, bubble_cnt 0.
REQ-032 stall_out SHALL be 0 while Reset=0; reset mid-stall abandons the stall.
REQ-033 First edge after Reset rises SHALL decode normally.

Verification
REQ-034 Sweep op 0000..1111, in_valid=1 -> next cycle flags per REQ-017, e.g. 1000 -> MemWrite=1, RegWrite=0; 1100 -> Branch=1.
REQ-035 STALL_CYCLES=1: load rd=3, then add rs=3 -> stall_out=1 one cycle, one bubble, add issued 2 edges after load, bubble_cnt=1.
REQ-036 STALL_CYCLES=3: same sequence -> stall_out=1 three cycles, three bubbles, add issued 4 edges after load, bubble_cnt=3.
REQ-037 flush=1 in second STALL cycle -> bubble, stall_out=0 that cycle, state RUN, next valid instr issued next edge, bubble_cnt unchanged.
REQ-038 MCODEBITS=6, instr=6'b010001 -> illegal=1 one cycle, out_valid=0; Reset=0 asserted mid-STALL -> all outputs 0 without clock edge.
REQ-039 Force 300 hazards -> bubble_cnt=255 and holds.
